// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - MEM-stage access controller in front of dm with a one-entry store buffer; `DM_LOAD_FWD_EN enables store-buffer forwarding
module dm_ctrl #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  memOp,
  input  logic [31:0] addr,
  input  logic [31:0] WData,
  input  logic [31:0] PC,
  output logic        stall,
  output logic [31:0] RData,
  output logic        mem_err,
  output logic        dm_MemWrite,
  output logic [9:0]  dm_A,
  output logic [31:0] dm_WData,
  output logic [31:0] dm_PC,
  output logic [31:0] dm_addr,
  input  logic [31:0] dm_RData
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SB  = 4'd10;

  logic        buf_valid;
  logic [9:0]  buf_A;
  logic [31:0] buf_data;
  logic [31:0] buf_PC;
  logic [31:0] buf_addr;

  logic [9:0]  a_idx;
  logic [1:0]  lane;
  logic        is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
  logic        is_load, is_store, is_word, is_half, needs_read;
  logic        misaligned, out_of_range, fault;
  logic        rd_conflict, accept;
  logic [31:0] base_word;
  logic [31:0] merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign a_idx = addr[11:2];
  assign lane  = addr[1:0];

  always_comb begin
    is_lw  = valid_in && (memOp == OP_LW);
    is_lh  = valid_in && (memOp == OP_LH);
    is_lhu = valid_in && (memOp == OP_LHU);
    is_lb  = valid_in && (memOp == OP_LB);
    is_lbu = valid_in && (memOp == OP_LBU);
    is_sw  = valid_in && (memOp == OP_SW);
    is_sh  = valid_in && (memOp == OP_SH);
    is_sb  = valid_in && (memOp == OP_SB);
    is_load    = is_lw | is_lh | is_lhu | is_lb | is_lbu;
    is_store   = is_sw | is_sh | is_sb;
    is_word    = is_lw | is_sw;
    is_half    = is_lh | is_lhu | is_sh;
    needs_read = is_load | is_sh | is_sb;
  end

  always_comb begin
    out_of_range = (addr >= ADDR_LIMIT);
    misaligned   = (is_word && (lane != 2'b00)) || (is_half && lane[0]);
    fault        = (is_load || is_store) && (out_of_range || misaligned);
  end

`ifdef DM_LOAD_FWD_EN
  logic hit;
  assign hit         = buf_valid && (buf_A == a_idx);
  assign rd_conflict = buf_valid && !hit;
  assign base_word   = hit ? buf_data : dm_RData;
`else
  // The single dm port is busy draining, so any read waits one cycle
  assign rd_conflict = buf_valid;
  assign base_word   = dm_RData;
`endif

  assign stall  = needs_read && !fault && rd_conflict;
  assign accept = (is_load || is_store) && !fault && !stall;

  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0: byte_sel = base_word[7:0];
      2'd1: byte_sel = base_word[15:8];
      2'd2: byte_sel = base_word[23:16];
      default: byte_sel = base_word[31:24];
    endcase
    half_sel = lane[1] ? base_word[31:16] : base_word[15:0];
  end

  always_comb begin
    merged = base_word;
    if (is_sw) begin
      merged = WData;
    end else if (is_sh) begin
      if (lane[1]) merged[31:16] = WData[15:0];
      else         merged[15:0]  = WData[15:0];
    end else if (is_sb) begin
      case (lane)
        2'd0: merged[7:0]   = WData[7:0];
        2'd1: merged[15:8]  = WData[7:0];
        2'd2: merged[23:16] = WData[7:0];
        default: merged[31:24] = WData[7:0];
      endcase
    end
  end

  always_comb begin
    RData = 32'h0;
    if (accept) begin
      if (is_lw)       RData = base_word;
      else if (is_lh)  RData = {{16{half_sel[15]}}, half_sel};
      else if (is_lhu) RData = {16'h0, half_sel};
      else if (is_lb)  RData = {{24{byte_sel[7]}}, byte_sel};
      else if (is_lbu) RData = {24'h0, byte_sel};
    end
  end

  always_comb begin
    if (buf_valid) begin
      dm_MemWrite = 1'b1;
      dm_A        = buf_A;
      dm_WData    = buf_data;
      dm_PC       = buf_PC;
      dm_addr     = buf_addr;
    end else begin
      dm_MemWrite = 1'b0;
      dm_A        = a_idx;
      dm_WData    = 32'h0;
      dm_PC       = PC;
      dm_addr     = addr;
    end
  end

  // Buffer drains every cycle it is full; an accepted store refills it on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_A     <= 10'h0;
      buf_data  <= 32'h0;
      buf_PC    <= 32'h0;
      buf_addr  <= 32'h0;
      mem_err   <= 1'b0;
    end else begin
      if (accept && is_store) begin
        buf_valid <= 1'b1;
        buf_A     <= a_idx;
        buf_data  <= merged;
        buf_PC    <= PC;
        buf_addr  <= addr;
      end else begin
        buf_valid <= 1'b0;
      end
      if (fault) mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - scoreboard bench for dm_ctrl with a behavioural dm model
module tb_dm_ctrl;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_SH   = 4'd9;
  localparam logic [3:0] OP_SB   = 4'd10;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [3:0]  memOp;
  logic [31:0] addr;
  logic [31:0] WData;
  logic [31:0] PC;
  logic        stall;
  logic [31:0] RData;
  logic        mem_err;
  logic        dm_MemWrite;
  logic [9:0]  dm_A;
  logic [31:0] dm_WData;
  logic [31:0] dm_PC;
  logic [31:0] dm_addr;
  logic [31:0] dm_RData;

  logic [31:0] mem [0:1023];
  logic [31:0] rq[$];
  wr_t         wq[$];
  wr_t         w;
  logic [31:0] r;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dm_ctrl #(.ADDR_LIMIT(32'h0000_1000)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .memOp(memOp), .addr(addr),
    .WData(WData), .PC(PC), .stall(stall), .RData(RData), .mem_err(mem_err),
    .dm_MemWrite(dm_MemWrite), .dm_A(dm_A), .dm_WData(dm_WData), .dm_PC(dm_PC),
    .dm_addr(dm_addr), .dm_RData(dm_RData)
  );

  assign dm_RData = mem[dm_A];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (dm_MemWrite) begin
      mem[dm_A] <= dm_WData;
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    valid_in = (op != OP_NONE);
    memOp    = op;
    addr     = a;
    WData    = d;
    PC       = 32'h100 + a;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic obs;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(OP_NONE, 32'h0, 32'h0);
    step; step; obs;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (RData !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", RData); end
    n_cmp++; if (dm_MemWrite !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", dm_MemWrite); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", mem_err); end
    reset = 1'b0;
  endtask

  task automatic test_sw_lw;
    step; drive(OP_SW, 32'h10, 32'h1234_5678); wq.push_back('{10'd4, 32'h1234_5678}); obs;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL swlw_sw_stall: got %b want 0", stall); end
    step; drive(OP_LW, 32'h10, 32'h0); rq.push_back(32'h1234_5678); obs;
    w = wq.pop_front();
    n_cmp++; if ({dm_MemWrite, dm_A, dm_WData} !== {1'b1, w.a, w.d})
      begin n_bad++; $display("FAIL swlw_drain: got we=%b A=%0d d=%h want we=1 A=%0d d=%h", dm_MemWrite, dm_A, dm_WData, w.a, w.d); end
`ifdef DM_LOAD_FWD_EN
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL swlw_fwd_stall: got %b want 0", stall); end
`else
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL swlw_stall: got %b want 1", stall); end
    step; obs;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL swlw_stall_len: got %b want 0", stall); end
`endif
    r = rq.pop_front();
    n_cmp++; if (RData !== r) begin n_bad++; $display("FAIL swlw_rdata: got %h want %h", RData, r); end
    step; drive(OP_NONE, 32'h0, 32'h0);
  endtask

  task automatic test_byte;
    step; drive(OP_SB, 32'h13, 32'h0000_00AB); wq.push_back('{10'd4, 32'hAB34_5678}); obs;
    n_cmp++; if ({stall, dm_MemWrite} !== 2'b00) begin n_bad++; $display("FAIL sb_issue: got stall=%b we=%b want 0 0", stall, dm_MemWrite); end
    step; drive(OP_LB, 32'h13, 32'h0); rq.push_back(32'hFFFF_FFAB); obs;
    w = wq.pop_front();
    n_cmp++; if ({dm_MemWrite, dm_A, dm_WData} !== {1'b1, w.a, w.d})
      begin n_bad++; $display("FAIL sb_drain: got we=%b A=%0d d=%h want we=1 A=%0d d=%h", dm_MemWrite, dm_A, dm_WData, w.a, w.d); end
`ifndef DM_LOAD_FWD_EN
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lb_stall: got %b want 1", stall); end
    step; obs;
`endif
    r = rq.pop_front();
    n_cmp++; if (RData !== r || stall !== 1'b0) begin n_bad++; $display("FAIL lb_rdata: got %h stall=%b want %h stall=0", RData, stall, r); end
    step; drive(OP_LBU, 32'h13, 32'h0); rq.push_back(32'h0000_00AB); obs;
    r = rq.pop_front();
    n_cmp++; if (RData !== r) begin n_bad++; $display("FAIL lbu_rdata: got %h want %h", RData, r); end
    n_cmp++; if (mem[4] !== 32'hAB34_5678) begin n_bad++; $display("FAIL sb_dm_word: got %h want ab345678", mem[4]); end
  endtask

  task automatic test_halfword;
    step; drive(OP_SH, 32'h16, 32'h1234_BEEF); wq.push_back('{10'd5, 32'hBEEF_0000}); obs;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sh_stall: got %b want 0", stall); end
    step; drive(OP_LH, 32'h16, 32'h0); rq.push_back(32'hFFFF_BEEF); obs;
    w = wq.pop_front();
    n_cmp++; if ({dm_MemWrite, dm_A, dm_WData} !== {1'b1, w.a, w.d})
      begin n_bad++; $display("FAIL sh_drain: got we=%b A=%0d d=%h want we=1 A=%0d d=%h", dm_MemWrite, dm_A, dm_WData, w.a, w.d); end
`ifndef DM_LOAD_FWD_EN
    step; obs;
`endif
    r = rq.pop_front();
    n_cmp++; if (RData !== r) begin n_bad++; $display("FAIL lh_rdata: got %h want %h", RData, r); end
    step; drive(OP_LHU, 32'h16, 32'h0); rq.push_back(32'h0000_BEEF); obs;
    r = rq.pop_front();
    n_cmp++; if (RData !== r) begin n_bad++; $display("FAIL lhu_rdata: got %h want %h", RData, r); end
  endtask

  task automatic test_struct_stall;
    step; drive(OP_SW, 32'h20, 32'hCAFE_F00D); wq.push_back('{10'd8, 32'hCAFE_F00D}); obs;
    step; drive(OP_LW, 32'h40, 32'h0); rq.push_back(32'h0); obs;
    w = wq.pop_front();
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ss_stall: got %b want 1", stall); end
    n_cmp++; if ({dm_MemWrite, dm_A, dm_WData} !== {1'b1, w.a, w.d})
      begin n_bad++; $display("FAIL ss_drain: got we=%b A=%0d d=%h want we=1 A=%0d d=%h", dm_MemWrite, dm_A, dm_WData, w.a, w.d); end
    n_cmp++; if (dm_PC !== 32'h120) begin n_bad++; $display("FAIL ss_pc: got %h want 120", dm_PC); end
    step; obs;
    n_cmp++; if ({stall, dm_MemWrite, dm_A} !== {1'b0, 1'b0, 10'd16})
      begin n_bad++; $display("FAIL ss_after: got stall=%b we=%b A=%0d want 0 0 16", stall, dm_MemWrite, dm_A); end
    r = rq.pop_front();
    n_cmp++; if (RData !== r) begin n_bad++; $display("FAIL ss_rdata: got %h want %h", RData, r); end
  endtask

  task automatic test_misaligned;
    step; drive(OP_LH, 32'h11, 32'h0); obs;
    n_cmp++; if ({stall, dm_MemWrite, mem_err, RData} !== {3'b000, 32'h0})
      begin n_bad++; $display("FAIL mis_cycle: got stall=%b we=%b err=%b rd=%h want 0 0 0 0", stall, dm_MemWrite, mem_err, RData); end
    step; drive(OP_NONE, 32'h0, 32'h0); obs;
    n_cmp++; if ({mem_err, dm_MemWrite} !== 2'b10) begin n_bad++; $display("FAIL mis_err: got err=%b we=%b want 1 0", mem_err, dm_MemWrite); end
    reset = 1'b1; step; reset = 1'b0; obs;
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL mis_err_clr: got %b want 0", mem_err); end
    step; drive(OP_SW, 32'h1000, 32'h55); obs;
    n_cmp++; if ({stall, dm_MemWrite} !== 2'b00) begin n_bad++; $display("FAIL range_cycle: got stall=%b we=%b want 0 0", stall, dm_MemWrite); end
    step; drive(OP_NONE, 32'h0, 32'h0); obs;
    n_cmp++; if ({mem_err, dm_MemWrite} !== 2'b10) begin n_bad++; $display("FAIL range_err: got err=%b we=%b want 1 0", mem_err, dm_MemWrite); end
    reset = 1'b1; step; reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      step; drive(OP_SW, 32'(4 * i), 32'hA0 + 32'(i)); wq.push_back('{10'(i), 32'hA0 + 32'(i)}); obs;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: i=%0d got %b want 0", i, stall); end
      if (i > 0) begin
        w = wq.pop_front();
        n_cmp++; if ({dm_MemWrite, dm_A, dm_WData} !== {1'b1, w.a, w.d})
          begin n_bad++; $display("FAIL b2b_drain: got we=%b A=%0d d=%h want we=1 A=%0d d=%h", dm_MemWrite, dm_A, dm_WData, w.a, w.d); end
      end
    end
    step; drive(OP_NONE, 32'h0, 32'h0); obs;
    w = wq.pop_front();
    n_cmp++; if ({dm_MemWrite, dm_A, dm_WData} !== {1'b1, w.a, w.d})
      begin n_bad++; $display("FAIL b2b_last: got we=%b A=%0d d=%h want we=1 A=%0d d=%h", dm_MemWrite, dm_A, dm_WData, w.a, w.d); end
    step; obs;
    n_cmp++; if (dm_MemWrite !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", dm_MemWrite); end
    n_cmp++; if ({mem[0], mem[1], mem[2]} !== {32'hA0, 32'hA1, 32'hA2})
      begin n_bad++; $display("FAIL b2b_dm: got %h %h %h want a0 a1 a2", mem[0], mem[1], mem[2]); end
  endtask

  task automatic test_reset_buffer_full;
    step; drive(OP_SW, 32'h30, 32'h7777_7777); obs;
    step; drive(OP_NONE, 32'h0, 32'h0); reset = 1'b1; obs;
    n_cmp++; if (dm_MemWrite !== 1'b1) begin n_bad++; $display("FAIL rst_pending: got %b want 1", dm_MemWrite); end
    step; reset = 1'b0; obs;
    n_cmp++; if ({dm_MemWrite, mem_err} !== 2'b00) begin n_bad++; $display("FAIL rst_buf: got we=%b err=%b want 0 0", dm_MemWrite, mem_err); end
    n_cmp++; if (mem[12] !== 32'h0) begin n_bad++; $display("FAIL rst_dm: got %h want 0", mem[12]); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_sw_lw;
    test_byte;
    test_halfword;
    test_struct_stall;
    test_misaligned;
    test_back_to_back;
    test_reset_buffer_full;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
